expr_tx: RTL and testbench
==========================

Name: expr_tx

Overview:
- Transmitter for the ASCII arithmetic-expression byte stream (grammar: digit (op digit)*, with op in '+' or '*').
- The host pushes tokens, each carrying one digit, an optional trailing operator, and a last flag. The block buffers them in a small FIFO and serialises them as one ASCII character per transfer on a valid/ready byte interface.
- The output stream drives the expression-string checker. Every completed expression from this block must be accepted by that checker.

Parameters:
- DEPTH, 4, token FIFO entries; power of 2, at least 2.
- AW, 2, FIFO pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  clock; all logic on posedge.
- clr  in  1  synchronous active-high reset.
- in_valid  in  1  token offered.
- in_ready  out  1  token FIFO not full.
- in_digit  in  4  operand value, 0..9.
- in_op  in  1  operator following the digit: 0 = '+', 1 = '*'. Ignored when in_last = 1.
- in_last  in  1  this digit ends the expression; no operator is emitted after it.
- out_char  out  8  ASCII character.
- out_valid  out  1  out_char is valid.
- out_ready  in  1  downstream accepts the character.
- out_last  out  1  qualifies out_char as the final digit of an expression.
- expr_ok  out  1  high once the final digit of an expression has transferred; low again when the next character transfers.
- err  out  1  sticky error flag; used only under EXPR_TX_CHECK_EN.

Behaviour:
- Reset (clr = 1 at posedge):
  - FIFO emptied, pointers and count = 0.
  - FSM enters IDLE; holding register cleared.
  - out_valid = 0, out_char = 8'h00, out_last = 0, expr_ok = 0, err = 0, in_ready = 1 on the next cycle.
  - clr has priority over every push, pop and transfer in that cycle. Any partially sent expression is dropped, and the next character sent is a digit.
- Push side:
  - in_ready = (count != DEPTH), derived from registered count only.
  - Push happens when in_valid && in_ready. A full FIFO refuses the push even if a pop occurs in the same cycle.
  - A simultaneous push and pop when not full leaves count unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, SEND_DIG, SEND_OP.
  - IDLE: if the FIFO is non-empty, pop the head into the holding register {digit, op, last} and go to SEND_DIG. Otherwise stay in IDLE.
  - SEND_DIG: out_valid = 1, out_char = 8'h30 + digit, out_last = last.
    - On out_valid && out_ready with last = 1: go to IDLE and set expr_ok = 1.
    - On out_valid && out_ready with last = 0: go to SEND_OP.
  - SEND_OP: out_valid = 1, out_char = op ? 8'h2A : 8'h2B, out_last = 0. On transfer, go to IDLE.
  - While out_ready = 0, out_char, out_valid and out_last hold stable; no character is dropped or repeated.
- Latency:
  - With an empty FIFO in IDLE, a token pushed at edge N gives out_valid at edge N+2.
  - Each token costs one IDLE bubble cycle plus one cycle per character when out_ready is held at 1.
- expr_ok:
  - Set on transfer of an out_last character.
  - Cleared on any later character transfer.
  - Cleared by clr.
- Stream guarantee: the emitted sequence alternates digit, operator, digit, and every expression ends on a digit.

Optional Feature:
- EXPR_TX_CHECK_EN defined:
  - A pushed token with in_digit > 9 is accepted (handshake completes) but discarded, and err is set at the next edge.
  - err stays set until clr.
  - While err = 1, in_ready is forced to 0 and the FSM finishes any character in flight and then idles.
- EXPR_TX_CHECK_EN not defined:
  - No range check; in_digit is emitted as 8'h30 + in_digit.
  - err is tied to 0.

Decomposition:
- Shared package/header (expr_pkg):
  - ASCII constants CH_ZERO = 8'h30, CH_PLUS = 8'h2B, CH_STAR = 8'h2A.
  - FSM state encodings S_IDLE, S_DIG, S_OP (2 bits).
  - Token field widths.
- Sub-module: expr_tok_fifo.
  - Synchronous FIFO, width 6 ({last, op, digit}), depth DEPTH, with push, pop, full, empty and count.
  - Instantiated once. The FSM and output registers stay in expr_tx.

Test Plan:
- Single token: push {digit 7, last 1}, out_ready = 1 → out_char 8'h37 at edge +2, out_last = 1, expr_ok = 1 on the following cycle.
- Expression "3+4*5": push {3, op 0}, {4, op 1}, {5, last} → out_char sequence 8'h33, 8'h2B, 8'h34, 8'h2A, 8'h35. The checker's output is 1 after the final char and 0 after each operator.
- Backpressure: out_ready = 0 for 5 cycles in SEND_OP → out_char = 8'h2B held and stable, no loss. With DEPTH 4, further pushes stop with in_ready = 0 once count = 4.
- Full plus pop in the same cycle: count = 4, in_valid = 1, pop occurring → push refused, count = 3 next cycle.
- Reset mid-expression: clr asserted in SEND_OP → out_valid = 0, FIFO empty. The next pushed token {9, last} emits 8'h39 first.
- With EXPR_TX_CHECK_EN: push digit 12 → err = 1, no character emitted, in_ready = 0 until clr.

Source files
------------

// File: rtl/expr_pkg.sv
// rtl/expr_pkg.sv - shared constants, token layout and FSM encodings for the expression transmitter
package expr_pkg;

  localparam int DIG_W = 4;
  localparam int TOK_W = DIG_W + 2;

  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_STAR = 8'h2A;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIG  = 2'd1,
    S_OP   = 2'd2
  } state_t;

  typedef struct packed {
    logic             last;
    logic             op;
    logic [DIG_W-1:0] digit;
  } tok_t;

  function automatic logic [7:0] dig_char(input logic [DIG_W-1:0] d);
    return CH_ZERO + {4'h0, d};
  endfunction

  function automatic logic [7:0] op_char(input logic op);
    return op ? CH_STAR : CH_PLUS;
  endfunction

endpackage

// File: rtl/expr_tok_fifo.sv
// rtl/expr_tok_fifo.sv - synchronous token FIFO holding {last, op, digit}
module expr_tok_fifo
  import expr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [TOK_W-1:0] wdata,
  output logic [TOK_W-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [TOK_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/expr_tx.sv
// rtl/expr_tx.sv - serialises buffered digit/operator tokens into an ASCII expression byte stream
// Optional digit range check and sticky err flag under EXPR_TX_CHECK_EN.
module expr_tx
  import expr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DIG_W-1:0] in_digit,
  input  logic             in_op,
  input  logic             in_last,
  output logic [7:0]       out_char,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             expr_ok,
  output logic             err
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  state_t           state;
  logic             hold_op;
  logic             hold_last;
  tok_t             wtok;
  tok_t             rtok;
  logic [TOK_W-1:0] rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [AW:0]      count;
  logic             push_hs;
  logic             fifo_push;
  logic             pop;
  logic             xfer;
  logic             digit_ok;

  assign push_hs   = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign wtok      = '{last: in_last, op: in_op & ~in_last, digit: in_digit};
  assign rtok      = rdata;
  assign fifo_push = push_hs && digit_ok && !fifo_full;

`ifdef EXPR_TX_CHECK_EN
  logic err_q;

  // Out-of-range digits complete the handshake but never reach the FIFO.
  assign digit_ok = (in_digit <= 4'd9);
  assign in_ready = (count != FULL_CNT) && !err_q;
  assign pop      = (state == S_IDLE) && !fifo_empty && !err_q;
  assign err      = err_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      err_q <= 1'b0;
    end else if (push_hs && !digit_ok) begin
      err_q <= 1'b1;
    end
  end
`else
  assign digit_ok = 1'b1;
  assign in_ready = (count != FULL_CNT);
  assign pop      = (state == S_IDLE) && !fifo_empty;
  assign err      = 1'b0;
`endif

  expr_tok_fifo #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_fifo (
    .clk  (clk),
    .clr  (clr),
    .push (fifo_push),
    .pop  (pop),
    .wdata(wtok),
    .rdata(rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(count)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= S_IDLE;
      hold_op   <= 1'b0;
      hold_last <= 1'b0;
      out_valid <= 1'b0;
      out_char  <= 8'h00;
      out_last  <= 1'b0;
      expr_ok   <= 1'b0;
    end else begin
      if (xfer) begin
        expr_ok <= out_last;
      end
      case (state)
        S_IDLE: begin
          if (pop) begin
            hold_op   <= rtok.op;
            hold_last <= rtok.last;
            out_valid <= 1'b1;
            out_char  <= dig_char(rtok.digit);
            out_last  <= rtok.last;
            state     <= S_DIG;
          end
        end
        S_DIG: begin
          // After an error the digit in flight finishes and no operator follows.
          if (xfer) begin
            if (hold_last || err) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= S_IDLE;
            end else begin
              out_char <= op_char(hold_op);
              out_last <= 1'b0;
              state    <= S_OP;
            end
          end
        end
        S_OP: begin
          if (xfer) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_expr_tx.sv
// tb/tb_expr_tx.sv - self-checking bench for expr_tx: vector table, corner sequences, random stream vs model
module tb_expr_tx;

  logic       clk = 1'b0;
  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_digit;
  logic       in_op;
  logic       in_last;
  logic [7:0] out_char;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       expr_ok;
  logic       err;

  expr_tx #(.DEPTH(4), .AW(2)) dut (
    .clk      (clk),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_digit (in_digit),
    .in_op    (in_op),
    .in_last  (in_last),
    .out_char (out_char),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .expr_ok  (expr_ok),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic       op;
    logic       last;
    logic [7:0] exp_dig;
    logic [7:0] exp_op;
  } vec_t;

  vec_t       tbl[10];
  int         n_vec = 0;
  int         n_bad = 0;
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  logic       mon_en = 1'b0;
  logic       exp_ok = 1'b0;
  logic       held = 1'b0;
  logic [7:0] held_char;
  logic       held_last;
  logic       rand_done;
  int         nt;
  logic [3:0] rd;
  logic       rop;
  logic       rlast;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: a token yields its digit character, then its operator unless it is last.
  task automatic expect_tok(input logic [3:0] d, input logic op, input logic last);
    exp_q.push_back({last, 8'd48 + {4'd0, d}});
    if (!last) exp_q.push_back({1'b0, op ? 8'd42 : 8'd43});
  endtask

  task automatic push_tok(input logic [3:0] d, input logic op, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_digit = d;
    in_op    = op;
    in_last  = last;
    while (!in_ready && n < 300) begin
      step();
      n++;
    end
    if (!in_ready) chk("push_timeout", 32'd0, 32'd1);
    else step();
    in_valid = 1'b0;
  endtask

  task automatic drain_cmp(input string tag);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (got_q.size() < exp_q.size() && n < 1000) begin
      step();
      n++;
    end
    repeat (3) step();
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) chk({tag, "_char"}, {23'd0, got_q[i]}, {23'd0, exp_q[i]});
    end
    chk({tag, "_idle"}, out_valid, 1'b0);
    got_q.delete();
    exp_q.delete();
  endtask

  // Stream monitor: records transfers, tracks expected expr_ok, and checks stability under backpressure.
  always @(negedge clk) begin
    if (mon_en) begin
      if (clr) begin
        exp_ok = 1'b0;
        held   = 1'b0;
      end else begin
        chk("expr_ok", expr_ok, exp_ok);
        if (held) begin
          chk("hold_valid", out_valid, 1'b1);
          chk("hold_char", out_char, held_char);
          chk("hold_last", out_last, held_last);
        end
        if (out_valid && out_ready) begin
          got_q.push_back({out_last, out_char});
          exp_ok = out_last;
          held   = 1'b0;
        end else if (out_valid) begin
          held      = 1'b1;
          held_char = out_char;
          held_last = out_last;
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4'd3, 1'b0, 1'b0, 8'h33, 8'h2B};
    tbl[1] = '{4'd4, 1'b1, 1'b0, 8'h34, 8'h2A};
    tbl[2] = '{4'd5, 1'b0, 1'b1, 8'h35, 8'h00};
    tbl[3] = '{4'd7, 1'b1, 1'b1, 8'h37, 8'h00};
    tbl[4] = '{4'd0, 1'b1, 1'b0, 8'h30, 8'h2A};
    tbl[5] = '{4'd9, 1'b0, 1'b1, 8'h39, 8'h00};
    tbl[6] = '{4'd9, 1'b0, 1'b0, 8'h39, 8'h2B};
    tbl[7] = '{4'd0, 1'b0, 1'b0, 8'h30, 8'h2B};
    tbl[8] = '{4'd1, 1'b1, 1'b0, 8'h31, 8'h2A};
    tbl[9] = '{4'd2, 1'b1, 1'b1, 8'h32, 8'h00};

    clr = 1'b1; in_valid = 1'b0; in_digit = 4'd0; in_op = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) step();
    clr = 1'b0;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_char", out_char, 8'h00);
    chk("rst_last", out_last, 1'b0);
    chk("rst_ok", expr_ok, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    mon_en = 1'b1;

    // Single token latency: push at edge N, character visible after N+1, expr_ok after transfer.
    out_ready = 1'b1;
    expect_tok(4'd7, 1'b0, 1'b1);
    in_valid = 1'b1; in_digit = 4'd7; in_op = 1'b0; in_last = 1'b1;
    step();
    in_valid = 1'b0;
    chk("lat_n_valid", out_valid, 1'b0);
    step();
    chk("lat_valid", out_valid, 1'b1);
    chk("lat_char", out_char, 8'h37);
    chk("lat_last", out_last, 1'b1);
    step();
    chk("lat_ok", expr_ok, 1'b1);
    chk("lat_done", out_valid, 1'b0);
    drain_cmp("single");

    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({tbl[i].last, tbl[i].exp_dig});
      if (!tbl[i].last) exp_q.push_back({1'b0, tbl[i].exp_op});
      push_tok(tbl[i].d, tbl[i].op, tbl[i].last);
    end
    drain_cmp("table");

    // Backpressure while the operator is pending.
    out_ready = 1'b0;
    expect_tok(4'd3, 1'b0, 1'b0);
    expect_tok(4'd4, 1'b0, 1'b1);
    push_tok(4'd3, 1'b0, 1'b0);
    step();
    chk("bp_dig", out_char, 8'h33);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_op_valid", out_valid, 1'b1);
      chk("bp_op_char", out_char, 8'h2B);
      step();
    end
    push_tok(4'd4, 1'b0, 1'b1);
    drain_cmp("backpressure");

    // Fill to DEPTH, then a pop with a refused push in the same cycle.
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      expect_tok(4'(i), 1'(i % 2 == 0), 1'b0);
      push_tok(4'(i), 1'(i % 2 == 0), 1'b0);
    end
    in_valid = 1'b1; in_digit = 4'd6; in_op = 1'b1; in_last = 1'b1;
    chk("full_ready0", in_ready, 1'b0);
    step();
    chk("full_ready1", in_ready, 1'b0);
    out_ready = 1'b1;
    step();
    chk("full_dig_x", in_ready, 1'b0);
    step();
    chk("full_op_x", in_ready, 1'b0);
    step();
    chk("full_pop_refuse", in_ready, 1'b1);
    step();
    chk("full_again", in_ready, 1'b0);
    in_valid = 1'b0;
    expect_tok(4'd6, 1'b1, 1'b1);
    drain_cmp("full");

    // Reset mid-expression with a token still queued.
    out_ready = 1'b0;
    push_tok(4'd8, 1'b1, 1'b0);
    push_tok(4'd2, 1'b0, 1'b1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("mid_op_char", out_char, 8'h2A);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_ready", in_ready, 1'b1);
    chk("mid_rst_ok", expr_ok, 1'b0);
    got_q.delete();
    exp_q.delete();
    out_ready = 1'b1;
    expect_tok(4'd9, 1'b0, 1'b1);
    push_tok(4'd9, 1'b0, 1'b1);
    drain_cmp("after_clr");

    // Randomised expressions with random gaps and random backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int e = 0; e < 30; e++) begin
          nt = $urandom_range(1, 4);
          for (int t = 0; t < nt; t++) begin
            rd    = 4'($urandom_range(0, 9));
            rop   = 1'($urandom_range(0, 1));
            rlast = (t == nt - 1);
            expect_tok(rd, rop, rlast);
            push_tok(rd, rop, rlast);
            repeat ($urandom_range(0, 2)) step();
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          step();
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain_cmp("random");

`ifdef EXPR_TX_CHECK_EN
    push_tok(4'd12, 1'b0, 1'b1);
    chk("chk_err", err, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("chk_ready", in_ready, 1'b0);
      chk("chk_nochar", out_valid, 1'b0);
      step();
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("chk_err_clr", err, 1'b0);
    chk("chk_ready_clr", in_ready, 1'b1);
`else
    chk("err_tied", err, 1'b0);
`endif

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
